// File: rtl/jolt160_mem_bridge.sv
// jolt160_mem_bridge
//
// Bridges the jolt160 CPU memory-access bus to an 8-bit acknowledged memory
// port. An 8-bit or 16-bit CPU request is split into one or two byte
// transactions. Bytes are issued big-endian: high byte at addr, low byte at
// addr+1, and addr+1 wraps around the address space. Read data returns on
// temp_data_in together with a one-cycle data_ready pulse. A byte that
// waits too long for mem_ack aborts the access and sets a sticky bus_error.
//
// Ports
//   clk             system clock, all state on the rising edge
//   reset           asynchronous active-low reset
//   req_rdwr        CPU request strobe (level), sampled only in IDLE
//   data_inout_we   1 = write, 0 = read
//   data_acc_sz     0 = 8-bit, 1 = 16-bit
//   data_inout_addr byte address of the access
//   temp_data_out   CPU write data
//   temp_data_in    read data to the CPU (registered, held between reads)
//   data_ready      one-cycle completion pulse (registered)
//   mem_addr        byte address to memory (registered)
//   mem_wdata       byte write data (registered)
//   mem_en          byte transaction request, held until ack or timeout
//   mem_we          byte write enable, qualified by mem_en
//   mem_rdata       byte read data, valid with mem_ack
//   mem_ack         memory accepts/completes the current byte this cycle
//   bus_error       sticky timeout flag, cleared only by reset
//   state_dbg       current FSM state (0 IDLE, 1 BYTE_HI, 2 BYTE_LO, 3 DONE)
//
// Handshake: a byte transfer completes on the rising edge where
// mem_en && mem_ack are both high. mem_en stays high, with address and data
// stable, until that edge or until the wait budget runs out. mem_ack seen
// while mem_en is low has no effect.

module jolt160_mem_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_rdwr,
    input  logic                  data_inout_we,
    input  logic                  data_acc_sz,
    input  logic [ADDR_WIDTH-1:0] data_inout_addr,
    input  logic [15:0]           temp_data_out,
    output logic [15:0]           temp_data_in,
    output logic                  data_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_en,
    output logic                  mem_we,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack,
    output logic                  bus_error,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BYTE_HI = 2'd1,
        ST_BYTE_LO = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // The wait counter holds the number of ack-less cycles already spent on
    // the current byte. A byte whose counter shows TIMEOUT_CYCLES-1 and still
    // sees no ack has waited TIMEOUT_CYCLES cycles and is abandoned. An ack
    // in that same final cycle still completes the byte.
    localparam logic [7:0]            WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    lat_we;
    logic                    lat_sz;
    logic [7:0]              lat_wdata_lo;
    logic [7:0]              read_hi;
    logic [7:0]              wait_cnt;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            lat_addr     <= '0;
            lat_we       <= 1'b0;
            lat_sz       <= 1'b0;
            lat_wdata_lo <= 8'h00;
            read_hi      <= 8'h00;
            wait_cnt     <= 8'h00;
            temp_data_in <= 16'h0000;
            data_ready   <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 8'h00;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_rdwr) begin
                        // Freeze the request; CPU inputs are not looked at
                        // again until the next IDLE.
                        lat_addr     <= data_inout_addr;
                        lat_we       <= data_inout_we;
                        lat_sz       <= data_acc_sz;
                        lat_wdata_lo <= temp_data_out[7:0];
                        read_hi      <= 8'h00;
                        wait_cnt     <= 8'h00;
                        mem_en       <= 1'b1;
                        mem_we       <= data_inout_we;
                        mem_addr     <= data_inout_addr;
                        if (data_acc_sz) begin
                            state     <= ST_BYTE_HI;
                            mem_wdata <= temp_data_out[15:8];
                        end else begin
                            state     <= ST_BYTE_LO;
                            mem_wdata <= temp_data_out[7:0];
                        end
                    end
                end

                ST_BYTE_HI: begin
                    if (mem_ack) begin
                        if (!lat_we) begin
                            read_hi <= mem_rdata;
                        end
                        state     <= ST_BYTE_LO;
                        mem_addr  <= lat_addr + ADDR_ONE;  // wraps naturally
                        mem_wdata <= lat_wdata_lo;
                        wait_cnt  <= 8'h00;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abort: low byte is never attempted.
                        state      <= ST_DONE;
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        data_ready <= 1'b1;
                        bus_error  <= 1'b1;
                        read_hi    <= 8'h00;
                        if (!lat_we) begin
                            temp_data_in <= 16'h0000;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                ST_BYTE_LO: begin
                    if (mem_ack) begin
                        if (!lat_we) begin
                            // An 8-bit read zero-extends: read_hi was cleared
                            // at accept and only BYTE_HI ever loads it.
                            temp_data_in <= {read_hi, mem_rdata};
                        end
                        state      <= ST_DONE;
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        data_ready <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= ST_DONE;
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        data_ready <= 1'b1;
                        bus_error  <= 1'b1;
                        read_hi    <= 8'h00;
                        if (!lat_we) begin
                            temp_data_in <= 16'h0000;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                ST_DONE: begin
                    // data_ready is high this cycle; req_rdwr is ignored here.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jolt160_mem_bridge.sv
// Directed testbench for jolt160_mem_bridge.
// A memory responder acknowledges each byte after a programmable number of
// wait cycles and logs every completed byte as {we, addr, data}. The log is
// compared against hand-written expected transfers.

module tb_jolt160_mem_bridge;

  localparam int ADDR_WIDTH     = 16;
  localparam int TIMEOUT_CYCLES = 15;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic                  req_rdwr = 1'b0;
  logic                  data_inout_we = 1'b0;
  logic                  data_acc_sz = 1'b0;
  logic [ADDR_WIDTH-1:0] data_inout_addr = '0;
  logic [15:0]           temp_data_out = 16'h0000;
  logic [15:0]           temp_data_in;
  logic                  data_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [7:0]            mem_rdata = 8'h00;
  logic                  mem_ack = 1'b0;
  logic                  bus_error;
  logic [1:0]            state_dbg;

  jolt160_mem_bridge #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_rdwr(req_rdwr),
    .data_inout_we(data_inout_we),
    .data_acc_sz(data_acc_sz),
    .data_inout_addr(data_inout_addr),
    .temp_data_out(temp_data_out),
    .temp_data_in(temp_data_in),
    .data_ready(data_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .bus_error(bus_error),
    .state_dbg(state_dbg)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0]  mem_model [logic [15:0]];
  logic [24:0] obs_q[$];
  logic [24:0] exp_q[$];

  int ack_delay = 0;
  bit ack_never = 1'b0;
  int wait_n = 0;

  // memory responder: drives ack/rdata on the falling edge
  always @(negedge clk) begin
    if (mem_ack) wait_n = 0;
    mem_ack = 1'b0;
    if (reset && mem_en) begin
      if (!ack_never && wait_n >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          obs_q.push_back({1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 8'h00;
          obs_q.push_back({1'b0, mem_addr, mem_rdata});
        end
      end else begin
        wait_n++;
      end
    end else begin
      wait_n = 0;
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected end before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // compare log entries recorded since index base against exp_q
  task automatic check_log(input string tag, input int base);
    int n;
    n = obs_q.size() - base;
    check({tag, "_log_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      check({tag, "_log_entry"}, {7'd0, obs_q[base + i]}, {7'd0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  // Count cycles after an accept edge until data_ready, scrambling the CPU
  // inputs meanwhile (the latched request must not change).
  task automatic wait_done(input string tag, output int lat, output int en_cyc, output bit saw_lo);
    bit seen;
    seen = 1'b0;
    lat = 0;
    en_cyc = 0;
    saw_lo = 1'b0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(negedge clk);
      req_rdwr = 1'b0;
      data_inout_addr = 16'($urandom_range(0, 65535));
      temp_data_out = 16'($urandom_range(0, 65535));
      data_inout_we = 1'($urandom_range(0, 1));
      data_acc_sz = 1'($urandom_range(0, 1));
      if (mem_en) en_cyc++;
      if (state_dbg == 2'd2) saw_lo = 1'b1;
      if (data_ready) begin
        seen = 1'b1;
        lat = i;
      end
    end
    check({tag, "_ready_seen"}, {31'd0, seen}, 32'd1);
    if (seen) check({tag, "_mem_en_in_done"}, {31'd0, mem_en}, 32'd0);
    @(negedge clk);
    check({tag, "_ready_one_cycle"}, {31'd0, data_ready}, 32'd0);
  endtask

  task automatic run_req(input string tag, input bit we, input bit sz,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         output int lat, output int en_cyc, output bit saw_lo,
                         output int base);
    @(negedge clk);
    base = obs_q.size();
    req_rdwr = 1'b1;
    data_inout_we = we;
    data_acc_sz = sz;
    data_inout_addr = addr;
    temp_data_out = wdata;
    @(posedge clk);
    wait_done(tag, lat, en_cyc, saw_lo);
  endtask

  initial begin
    int lat, en_cyc, base;
    bit saw_lo;

    // reset
    repeat (3) @(negedge clk);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_data_ready", {31'd0, data_ready}, 32'd0);
    check("rst_bus_error", {31'd0, bus_error}, 32'd0);
    check("rst_temp_data_in", {16'd0, temp_data_in}, 32'h0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'h0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b1;

    mem_model[16'h1000] = 8'hAB;
    mem_model[16'h1001] = 8'hCD;
    mem_model[16'h0040] = 8'h7F;

    // 16-bit read, zero-wait
    ack_delay = 0;
    run_req("rd16", 1'b0, 1'b1, 16'h1000, 16'h0000, lat, en_cyc, saw_lo, base);
    check("rd16_latency", lat, 32'd3);
    check("rd16_data", {16'd0, temp_data_in}, 32'hABCD);
    exp_q.push_back({1'b0, 16'h1000, 8'hAB});
    exp_q.push_back({1'b0, 16'h1001, 8'hCD});
    check_log("rd16", base);

    // 8-bit write at odd address uses low data byte
    run_req("wr8", 1'b1, 1'b0, 16'h2001, 16'h55AA, lat, en_cyc, saw_lo, base);
    check("wr8_latency", lat, 32'd2);
    check("wr8_data_in_held", {16'd0, temp_data_in}, 32'hABCD);
    exp_q.push_back({1'b1, 16'h2001, 8'hAA});
    check_log("wr8", base);

    // 16-bit write across the wrap point, 3 wait cycles per byte
    ack_delay = 3;
    run_req("wr16wrap", 1'b1, 1'b1, 16'hFFFF, 16'h1234, lat, en_cyc, saw_lo, base);
    check("wr16wrap_latency", lat, 32'd9);
    check("wr16wrap_en_cycles", en_cyc, 32'd8);
    check("wr16wrap_data_in_held", {16'd0, temp_data_in}, 32'hABCD);
    exp_q.push_back({1'b1, 16'hFFFF, 8'h12});
    exp_q.push_back({1'b1, 16'h0000, 8'h34});
    check_log("wr16wrap", base);

    // 8-bit read zero-extends
    ack_delay = 0;
    run_req("rd8", 1'b0, 1'b0, 16'h0040, 16'hFFFF, lat, en_cyc, saw_lo, base);
    check("rd8_latency", lat, 32'd2);
    check("rd8_data", {16'd0, temp_data_in}, 32'h007F);
    exp_q.push_back({1'b0, 16'h0040, 8'h7F});
    check_log("rd8", base);

    // ack in the last allowed cycle still succeeds
    ack_delay = TIMEOUT_CYCLES - 1;
    run_req("ack_last", 1'b0, 1'b1, 16'h1000, 16'h0000, lat, en_cyc, saw_lo, base);
    check("ack_last_latency", lat, 32'd31);
    check("ack_last_data", {16'd0, temp_data_in}, 32'hABCD);
    check("ack_last_bus_error", {31'd0, bus_error}, 32'd0);
    exp_q.push_back({1'b0, 16'h1000, 8'hAB});
    exp_q.push_back({1'b0, 16'h1001, 8'hCD});
    check_log("ack_last", base);

    // no ack at all: timeout on the high byte
    ack_never = 1'b1;
    run_req("tmo", 1'b0, 1'b1, 16'h3000, 16'h0000, lat, en_cyc, saw_lo, base);
    check("tmo_latency", lat, 32'd16);
    check("tmo_en_cycles", en_cyc, 32'd15);
    check("tmo_saw_byte_lo", {31'd0, saw_lo}, 32'd0);
    check("tmo_data", {16'd0, temp_data_in}, 32'h0000);
    check("tmo_bus_error", {31'd0, bus_error}, 32'd1);
    check_log("tmo", base);

    // bus_error is sticky across a good access
    ack_never = 1'b0;
    ack_delay = 0;
    run_req("after_tmo", 1'b0, 1'b0, 16'h0040, 16'h0000, lat, en_cyc, saw_lo, base);
    check("after_tmo_latency", lat, 32'd2);
    check("after_tmo_data", {16'd0, temp_data_in}, 32'h007F);
    check("after_tmo_bus_error", {31'd0, bus_error}, 32'd1);

    // reset in BYTE_LO of a 16-bit read, request held high through it
    ack_delay = 3;
    @(negedge clk);
    req_rdwr = 1'b1;
    data_inout_we = 1'b0;
    data_acc_sz = 1'b1;
    data_inout_addr = 16'h1000;
    @(posedge clk);
    repeat (5) @(negedge clk);
    check("mid_state_byte_lo", {30'd0, state_dbg}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("mid_rst_data_ready", {31'd0, data_ready}, 32'd0);
    check("mid_rst_bus_error", {31'd0, bus_error}, 32'd0);
    check("mid_rst_temp_data_in", {16'd0, temp_data_in}, 32'h0);
    check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    ack_delay = 0;
    #1 reset = 1'b1;
    base = obs_q.size();
    @(posedge clk);
    #1;
    check("restart_state", {30'd0, state_dbg}, 32'd1);
    check("restart_mem_en", {31'd0, mem_en}, 32'd1);
    check("restart_mem_addr", {16'd0, mem_addr}, 32'h1000);
    wait_done("restart", lat, en_cyc, saw_lo);
    check("restart_latency", lat, 32'd3);
    check("restart_data", {16'd0, temp_data_in}, 32'hABCD);
    check("restart_bus_error", {31'd0, bus_error}, 32'd0);
    exp_q.push_back({1'b0, 16'h1000, 8'hAB});
    exp_q.push_back({1'b0, 16'h1001, 8'hCD});
    check_log("restart", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
